// File: rtl/riscv_pkg.sv
// Shared RV32 encoding constants, instruction-format and FSM-state types
// used by the instruction encoder and its immediate packer.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  function automatic fmt_e decode_fmt(input logic [6:0] op);
    case (op)
      OP_REG:                     return FMT_R;
      OP_LOAD, OP_IMM, OP_JALR:   return FMT_I;
      OP_STORE:                   return FMT_S;
      OP_BRANCH:                  return FMT_B;
      OP_LUI, OP_AUIPC:           return FMT_U;
      OP_JAL:                     return FMT_J;
      default:                    return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters the immediate into its format-specific bit positions and flags
// immediates that do not fit the format (or opcodes that have no format).
module imm_pack
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] imm,
  output fmt_e        fmt,
  output logic [31:0] imm_bits,
  output logic        err
);

  logic uni11, uni12, uni20;

  // A field fits when every bit above its sign bit equals that sign bit.
  assign uni11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign uni12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign uni20 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    fmt      = decode_fmt(opcode);
    imm_bits = '0;
    err      = 1'b0;
    case (fmt)
      FMT_I: begin
        imm_bits = {imm[11:0], 20'b0};
        err      = !uni11;
      end
      FMT_S: begin
        imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        err      = !uni11;
      end
      FMT_B: begin
        imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        err      = imm[0] | !uni12;
      end
      FMT_U: begin
        imm_bits = {imm[31:12], 12'b0};
        err      = |imm[11:0];
      end
      FMT_J: begin
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        err      = imm[0] | !uni20;
      end
      FMT_BAD: err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streams decoded instruction fields into 32-bit RV32 words, tagging each
// with its instruction-memory address and an immediate/opcode error flag.
module inst_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst_word,
  output logic [31:0] out_addr,
  output logic        imm_err,
  output logic [7:0]  err_count,
  output logic        done
);

  state_e      state;
  logic [31:0] base_r;
  logic [15:0] len_r;
  logic [15:0] idx;
  fmt_e        fmt;
  logic [31:0] imm_bits;
  logic [31:0] fields;
  logic        pack_err;
  logic        accept;
  logic        emit;

  imm_pack u_pack (
    .opcode   (opcode),
    .imm      (imm),
    .fmt      (fmt),
    .imm_bits (imm_bits),
    .err      (pack_err)
  );

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  // Register fields each format carries; unknown opcodes collapse to a NOP.
  always_comb begin
    fields = NOP_WORD;
    case (fmt)
      FMT_R:        fields = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:        fields = {12'b0, rs1, funct3, rd, opcode};
      FMT_S, FMT_B: fields = {7'b0, rs2, rs1, funct3, 5'b0, opcode};
      FMT_U, FMT_J: fields = {20'b0, rd, opcode};
      default:      fields = NOP_WORD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_r    <= '0;
      len_r     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      inst_word <= '0;
      out_addr  <= '0;
      imm_err   <= 1'b0;
      err_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (emit) out_valid <= 1'b0;
      if (emit && imm_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      // An accept in the same cycle as an emit keeps out_valid high.
      if (accept) begin
        out_valid <= 1'b1;
        inst_word <= fields | imm_bits;
        out_addr  <= base_r + {14'b0, idx, 2'b00};
        imm_err   <= pack_err;
        idx       <= idx + 16'd1;
      end
      case (state)
        IDLE: if (start) begin
          base_r    <= base_addr;
          len_r     <= len;
          idx       <= '0;
          err_count <= '0;
          if (len == 16'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN:   if (accept && idx == len_r - 16'd1) state <= DRAIN;
        DRAIN: if (emit) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Drives directed and random bundle sequences into inst_encoder and checks
// every emitted word against an arithmetic model of the RV32 encodings.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_word;
  logic [31:0] out_addr;
  logic        imm_err;
  logic [7:0]  err_count;
  logic        done;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bundle_t;

  bundle_t     seq[$];
  logic [31:0] got_word[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_err[$];
  int          total = 0;
  int          bad = 0;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .inst_word(inst_word),
    .out_addr(out_addr), .imm_err(imm_err), .err_count(err_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Encoding model: bit positions and legal signed ranges of each format.
  function automatic logic [32:0] refEncode(input bundle_t b);
    longint      s;
    logic [31:0] w, rdf, rs1f, rs2f, f3f, f7f, opf;
    logic        e;
    s    = longint'($signed(b.imm));
    rdf  = 32'(b.rd) << 7;
    f3f  = 32'(b.f3) << 12;
    rs1f = 32'(b.rs1) << 15;
    rs2f = 32'(b.rs2) << 20;
    f7f  = 32'(b.f7) << 25;
    opf  = 32'(b.op);
    e    = 1'b0;
    case (b.op)
      7'b0110011: w = f7f | rs2f | rs1f | f3f | rdf | opf;
      7'b0000011, 7'b0010011, 7'b1100111: begin
        w = ((b.imm & 32'hFFF) << 20) | rs1f | f3f | rdf | opf;
        e = (s < -2048) || (s > 2047);
      end
      7'b0100011: begin
        w = (((b.imm >> 5) & 32'h7F) << 25) | rs2f | rs1f | f3f | ((b.imm & 32'h1F) << 7) | opf;
        e = (s < -2048) || (s > 2047);
      end
      7'b1100011: begin
        w = (((b.imm >> 12) & 32'h1) << 31) | (((b.imm >> 5) & 32'h3F) << 25) | rs2f | rs1f | f3f
          | (((b.imm >> 1) & 32'hF) << 8) | (((b.imm >> 11) & 32'h1) << 7) | opf;
        e = (s % 2 != 0) || (s < -4096) || (s > 4095);
      end
      7'b0110111, 7'b0010111: begin
        w = (b.imm & 32'hFFFFF000) | rdf | opf;
        e = (b.imm % 4096) != 0;
      end
      7'b1101111: begin
        w = (((b.imm >> 20) & 32'h1) << 31) | (((b.imm >> 1) & 32'h3FF) << 21)
          | (((b.imm >> 11) & 32'h1) << 20) | (((b.imm >> 12) & 32'hFF) << 12) | rdf | opf;
        e = (s % 2 != 0) || (s < -1048576) || (s > 1048575);
      end
      default: begin
        w = 32'h00000013;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  function automatic bundle_t mk(input logic [6:0] op, input logic [4:0] rdv, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic [2:0] f3, input logic [31:0] iv);
    bundle_t b;
    b.op = op; b.rd = rdv; b.rs1 = r1; b.rs2 = r2; b.f3 = f3; b.f7 = 7'h0; b.imm = iv;
    return b;
  endfunction

  function automatic bundle_t randBundle();
    logic [6:0] ops[10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    bundle_t b;
    int r;
    r    = $urandom_range(10);
    b.op = (r == 10) ? 7'($urandom) : ops[r];
    b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.f3 = 3'($urandom); b.f7 = 7'($urandom);
    case ($urandom_range(4))
      0:       b.imm = 32'($urandom_range(4095)) - 32'd2048;
      1:       b.imm = 32'($urandom_range(16383)) - 32'd8192;
      2:       b.imm = $urandom & 32'hFFFFF000;
      3:       b.imm = 32'($urandom_range(4194303)) - 32'd2097152;
      default: b.imm = $urandom;
    endcase
    return b;
  endfunction

  task automatic applyStimulus(input bundle_t b, input logic v);
    in_valid = v;
    opcode = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
    funct3 = b.f3; funct7 = b.f7; imm = b.imm;
  endtask

  task automatic startSeq(input logic [31:0] base, input int n);
    @(negedge clk);
    start = 1'b1; base_addr = base; len = 16'(n);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; len = 16'($urandom);
  endtask

  // Runs seq[0..n-1] with random valid/ready duty and checks every cycle.
  task automatic runSeq(input logic [31:0] base, input int n, input int pv, input int pr);
    int          sent = 0, emitted = 0, cycles = 0, errs = 0;
    logic        pend = 1'b0, rdy;
    logic [32:0] exp_q[$], e;
    logic [31:0] addr_q[$], a;
    got_word.delete(); got_addr.delete(); got_err.delete();
    startSeq(base, n);
    while (emitted < n && cycles < 2000) begin
      out_ready = ($urandom_range(99) < pr);
      if (sent < n && $urandom_range(99) < pv) applyStimulus(seq[sent], 1'b1);
      else applyStimulus(randBundle(), 1'b0);
      #1;
      rdy = (sent < n) && (!pend || out_ready);
      checkOutput("in_ready", in_ready, rdy);
      checkOutput("out_valid", out_valid, pend);
      checkOutput("done_low", done, 0);
      if (pend && out_ready) begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        checkOutput("inst_word", inst_word, e[31:0]);
        checkOutput("out_addr", out_addr, a);
        checkOutput("imm_err", imm_err, e[32]);
        got_word.push_back(inst_word); got_addr.push_back(out_addr); got_err.push_back(imm_err);
        if (e[32]) errs++;
        emitted++;
        pend = 1'b0;
      end
      if (in_valid && rdy) begin
        exp_q.push_back(refEncode(seq[sent]));
        addr_q.push_back(base + 32'(4 * sent));
        pend = 1'b1;
        sent++;
      end
      cycles++;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("seq_emitted", emitted, n);
    in_valid = 1'b0;
    #1;
    checkOutput("done_pulse", done, 1);
    checkOutput("out_valid_end", out_valid, 0);
    checkOutput("err_count", err_count, (errs > 255) ? 255 : errs);
    @(negedge clk);
    checkOutput("done_clear", done, 0);
  endtask

  initial begin
    bundle_t     b;
    logic [32:0] r0, r1, r2;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    applyStimulus(mk(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0), 1'b0);
    #1;
    checkOutput("rst_inst_word", inst_word, 0);
    checkOutput("rst_out_addr", out_addr, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed sequence at 0x100");
    seq = '{mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5),
            mk(7'h23, 5'd31, 5'd3, 5'd2, 3'd2, 32'd8),
            mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4),
            mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048)};
    runSeq(32'h100, 4, 100, 100);
    checkOutput("addi_word", got_word[0], 32'h00500093);
    checkOutput("sw_word", got_word[1], 32'h0021A423);
    checkOutput("beq_word", got_word[2], 32'hFE000EE3);
    checkOutput("jal_word", got_word[3], 32'h001000EF);
    checkOutput("addr0", got_addr[0], 32'h100);
    checkOutput("addr3", got_addr[3], 32'h10C);
    checkOutput("addi_err", got_err[0], 0);

    seq = '{mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096)};
    runSeq(32'h40, 1, 100, 100);
    checkOutput("addi_big_word", got_word[0], 32'h00000093);
    checkOutput("addi_big_err", got_err[0], 1);
    checkOutput("err_count_one", err_count, 1);

    seq = '{mk(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 32'd12)};
    runSeq(32'h80, 1, 100, 100);
    checkOutput("bad_op_word", got_word[0], 32'h00000013);
    checkOutput("bad_op_err", got_err[0], 1);

    $display("[TB] output stall for three cycles");
    seq = '{mk(7'h13, 5'd5, 5'd6, 5'd0, 3'd0, -32'sd1),
            mk(7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 32'hABCDE000),
            mk(7'h33, 5'd8, 5'd9, 5'd10, 3'd4, 32'd0)};
    r0 = refEncode(seq[0]); r1 = refEncode(seq[1]); r2 = refEncode(seq[2]);
    startSeq(32'h200, 3);
    out_ready = 1'b0;
    applyStimulus(seq[0], 1'b1);
    #1 checkOutput("stall_first_ready", in_ready, 1);
    @(posedge clk); @(negedge clk);
    applyStimulus(seq[1], 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_word", inst_word, r0[31:0]);
      checkOutput("stall_addr", out_addr, 32'h200);
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    #1 checkOutput("release_in_ready", in_ready, 1);
    @(posedge clk); @(negedge clk);
    applyStimulus(seq[2], 1'b1);
    #1;
    checkOutput("b2b_word1", inst_word, r1[31:0]);
    checkOutput("b2b_addr1", out_addr, 32'h204);
    checkOutput("b2b_ready1", in_ready, 1);
    @(posedge clk); @(negedge clk);
    applyStimulus(randBundle(), 1'b0);
    #1;
    checkOutput("b2b_valid2", out_valid, 1);
    checkOutput("b2b_word2", inst_word, r2[31:0]);
    checkOutput("b2b_addr2", out_addr, 32'h208);
    @(posedge clk); @(negedge clk);
    checkOutput("stall_done", done, 1);
    @(negedge clk);

    $display("[TB] empty and wrapping sequences");
    seq.delete();
    runSeq(32'h500, 0, 100, 100);
    seq = '{mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1), mk(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2)};
    runSeq(32'hFFFFFFFC, 2, 100, 100);
    checkOutput("wrap_addr0", got_addr[0], 32'hFFFFFFFC);
    checkOutput("wrap_addr1", got_addr[1], 32'h00000000);

    $display("[TB] reset in the middle of a sequence");
    b = mk(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd77);
    startSeq(32'h300, 4);
    out_ready = 1'b0;
    applyStimulus(b, 1'b1);
    @(posedge clk); @(negedge clk);
    applyStimulus(randBundle(), 1'b0);
    #1 checkOutput("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_in_ready", in_ready, 0);
    checkOutput("arst_inst_word", inst_word, 0);
    checkOutput("arst_out_addr", out_addr, 0);
    checkOutput("arst_imm_err", imm_err, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seq.delete();
    for (int i = 0; i < 5; i++) seq.push_back(randBundle());
    runSeq(32'h600, 5, 100, 100);

    $display("[TB] random sequences");
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(12, 1);
      seq.delete();
      for (int i = 0; i < n; i++) seq.push_back(randBundle());
      runSeq($urandom, n, 70, 60);
    end

    $display("[TB] error counter saturation");
    seq.delete();
    for (int i = 0; i < 300; i++) seq.push_back(mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'($urandom)));
    runSeq(32'h1000, 300, 100, 100);
    checkOutput("err_count_sat", err_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
